// File: rtl/mult_share_ctrl.sv
// Sequencer and round-robin arbiter for the shared shift-add multiplier datapath.
// Two requesters compete for one datapath. A grant is held for a whole
// operation, through Done, until the granted requester releases its request.
module mult_share_ctrl #(
   parameter int unsigned WIDTH = 8
) (
   input  logic       Clk,
   input  logic       Reset_n,
   input  logic       Clr,
   input  logic [1:0] Req,
   input  logic       M,
   output logic [1:0] Gnt,
   output logic       Sel,
   output logic       Busy,
   output logic       Clr_Ld,
   output logic       Add,
   output logic       Sub,
   output logic       Shift,
   output logic       Done
);

   localparam int unsigned CNT_W = $clog2(WIDTH) + 1;
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      LOAD     = 3'd1,
      ADD      = 3'd2,
      SHIFT    = 3'd3,
      DONE     = 3'd4,
      WAIT_REL = 3'd5
   } state_t;

   state_t             state, state_n;
   logic [CNT_W-1:0]   cnt, cnt_n;
   logic               last, last_n;
   logic [1:0]         gnt_q, gnt_n;
   logic               idx;

   // State, iteration count, round-robin pointer and grant registers
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state <= IDLE;
         cnt   <= '0;
         last  <= 1'b1;
         gnt_q <= 2'b00;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
         last  <= last_n;
         gnt_q <= gnt_n;
      end
   end

   // Next-state, arbitration and strobe decode; Clr overrides every transition
   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      last_n  = last;
      gnt_n   = gnt_q;
      idx     = 1'b0;
      Busy    = 1'b1;
      Clr_Ld  = 1'b0;
      Add     = 1'b0;
      Sub     = 1'b0;
      Shift   = 1'b0;
      Done    = 1'b0;

      case (state)
         IDLE:    Busy   = 1'b0;
         LOAD:    Clr_Ld = 1'b1;
         ADD: begin
            // The MSB of a two's-complement multiplier carries negative weight
            if (M) begin
               if (cnt == LAST_BIT) Sub = 1'b1;
               else                 Add = 1'b1;
            end
         end
         SHIFT:   Shift  = 1'b1;
         DONE:    Done   = 1'b1;
         default: ;
      endcase

      if (Clr) begin
         state_n = IDLE;
         gnt_n   = 2'b00;
         cnt_n   = '0;
      end else begin
         case (state)
            IDLE: begin
               case (Req)
                  2'b01:   idx = 1'b0;
                  2'b10:   idx = 1'b1;
                  2'b11:   idx = ~last;
                  default: idx = 1'b0;
               endcase
               if (Req != 2'b00) begin
                  state_n = LOAD;
                  gnt_n   = idx ? 2'b10 : 2'b01;
                  last_n  = idx;
               end
            end
            LOAD: begin
               cnt_n   = '0;
               state_n = ADD;
            end
            ADD:   state_n = SHIFT;
            SHIFT: begin
               cnt_n   = cnt + CNT_W'(1);
               state_n = (cnt == LAST_BIT) ? DONE : ADD;
            end
            DONE:  state_n = WAIT_REL;
            WAIT_REL: begin
               // Only the granted requester's release matters here
               if (!Req[gnt_q[1]]) begin
                  state_n = IDLE;
                  gnt_n   = 2'b00;
               end
            end
            default: begin
               state_n = IDLE;
               gnt_n   = 2'b00;
            end
         endcase
      end
   end

   assign Gnt = gnt_q;
   assign Sel = gnt_q[1];

endmodule

// File: tb/tb_mult_share_ctrl.sv
// Directed bench for mult_share_ctrl (WIDTH=8): grant, strobe timing, round-robin, abort paths.
module tb_mult_share_ctrl;

   logic       Clk;
   logic       Reset_n;
   logic       Clr;
   logic [1:0] Req;
   logic       M;
   logic [1:0] Gnt;
   logic       Sel, Busy, Clr_Ld, Add, Sub, Shift, Done;

   int n_vec = 0;
   int n_err = 0;

   mult_share_ctrl #(.WIDTH(8)) dut (
      .Clk    (Clk),
      .Reset_n(Reset_n),
      .Clr    (Clr),
      .Req    (Req),
      .M      (M),
      .Gnt    (Gnt),
      .Sel    (Sel),
      .Busy   (Busy),
      .Clr_Ld (Clr_Ld),
      .Add    (Add),
      .Sub    (Sub),
      .Shift  (Shift),
      .Done   (Done)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   // Observed outputs packed as {Gnt, Sel, Busy, Clr_Ld, Add, Sub, Shift, Done}
   function automatic logic [8:0] obs();
      return {Gnt, Sel, Busy, Clr_Ld, Add, Sub, Shift, Done};
   endfunction

   task automatic chk(input string tag, input logic [8:0] got, input logic [8:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%b exp=%b", tag, got, exp);
      end
   endtask

   // Advance to the next cycle: inputs change just after the edge, checks 2 time units later
   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   // Expected outputs in cycle c of an operation (cycle 0 = IDLE cycle with Req sampled)
   function automatic logic [8:0] exp_vec(input int c, input logic [1:0] g, input logic [7:0] mp);
      logic cl, ad, sb, sh, dn;
      cl = (c == 1);
      ad = (c >= 2) && (c <= 14) && (c % 2 == 0) && mp[(c - 2) / 2];
      sb = (c == 16) && mp[7];
      sh = (c >= 3) && (c <= 17) && (c % 2 == 1);
      dn = (c == 18);
      return {g, g[1], 1'b1, cl, ad, sb, sh, dn};
   endfunction

   // Run one operation from IDLE and check cycles 1..stop_cyc; Req drops at drop_cyc (0 = never)
   task automatic run_op(input string tag, input logic [1:0] req, input logic [7:0] mp,
                         input logic [1:0] g, input int drop_cyc, input int stop_cyc);
      Req = req;
      for (int c = 1; c <= stop_cyc; c++) begin
         tick();
         M = ((c % 2 == 0) && (c >= 2) && (c <= 16)) ? mp[(c - 2) / 2] : 1'b0;
         if (c == drop_cyc) Req = 2'b00;
         #1;
         chk($sformatf("%s_c%0d", tag, c), obs(), exp_vec(c, g, mp));
      end
   endtask

   task automatic release_and_idle(input string tag);
      Req = 2'b00;
      tick();
      #1;
      chk(tag, obs(), 9'b0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      Reset_n = 1'b0;
      Clr     = 1'b0;
      Req     = 2'b01;
      M       = 1'b0;
      #23;
      chk("reset_state", obs(), 9'b0);

      // Release reset with Req high; grant follows on the first edge. M=1 throughout.
      Reset_n = 1'b1;
      run_op("allm1", 2'b01, 8'hFF, 2'b01, 0, 19);
      for (int c = 20; c <= 21; c++) begin
         tick();
         #1;
         chk($sformatf("hold_c%0d", c), obs(), {2'b01, 1'b0, 1'b1, 5'b0});
      end
      release_and_idle("allm1_idle");

      // Multiplier 0xA5 LSB-first
      run_op("a5", 2'b01, 8'hA5, 2'b01, 0, 19);
      release_and_idle("a5_idle");

      // Round-robin from a fresh reset
      #3;
      Reset_n = 1'b0;
      #1;
      chk("rst_pulse", obs(), 9'b0);
      Reset_n = 1'b1;
      run_op("rr1", 2'b11, 8'h3C, 2'b01, 0, 19);
      Req = 2'b10;
      tick();
      #1;
      chk("rr_gap", obs(), 9'b0);
      run_op("rr2", 2'b10, 8'h81, 2'b10, 0, 19);
      release_and_idle("rr2_idle");
      run_op("rr3", 2'b11, 8'h00, 2'b01, 0, 19);
      // Other requester is ignored while waiting for release
      Req = 2'b10;
      tick();
      #1;
      chk("rr3_ignore", obs(), 9'b0);
      release_and_idle("rr3_idle");

      // Async reset during SHIFT with cnt=3 (cycle 9)
      run_op("rst9", 2'b01, 8'hFF, 2'b01, 0, 9);
      Reset_n = 1'b0;
      #1;
      chk("rst9_async", obs(), 9'b0);
      Req = 2'b00;
      #1;
      Reset_n = 1'b1;
      tick();
      #1;
      chk("rst9_idle", obs(), 9'b0);

      // Clr during ADD with cnt=4 (cycle 10), Req held
      run_op("clr10", 2'b01, 8'hFF, 2'b01, 0, 10);
      Clr = 1'b1;
      tick();
      Clr = 1'b0;
      #1;
      chk("clr10_idle", obs(), 9'b0);
      run_op("clr_regrant", 2'b01, 8'hFF, 2'b01, 0, 19);
      release_and_idle("clr_regrant_idle");

      // Clr in IDLE blocks a grant that edge
      Req = 2'b01;
      Clr = 1'b1;
      tick();
      Clr = 1'b0;
      #1;
      chk("clr_idle_nogrant", obs(), 9'b0);

      // Req dropped at cycle 5: operation completes, IDLE at cycle 20
      run_op("drop5", 2'b01, 8'h5A, 2'b01, 5, 19);
      tick();
      #1;
      chk("drop5_c20", obs(), 9'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
